// File: rtl/serial_op_engine_if.sv
// Handshake and control bundle for serial_op_engine.
// Valid/ready rule for both streams: a beat transfers on a rising clk edge
// where valid and ready are both high; the producer keeps valid and data
// stable until that edge, and ready never depends combinationally on valid.
interface serial_op_engine_if #(
  parameter int W      = 4,
  parameter int ITER_W = 4
);
  logic              start;
  logic [2:0]        op;
  logic [ITER_W-1:0] iters;
  logic              acc_clr;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      a_in;
  logic [W-1:0]      b_in;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic              out_last;
  logic              busy;
  logic [1:0]        state_o;

  // Job issuer / stream source and sink side.
  modport master (
    output start, op, iters, acc_clr, in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, state_o
  );

  // Engine side.
  modport slave (
    input  start, op, iters, acc_clr, in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, state_o
  );
endinterface

// File: rtl/serial_op_engine.sv
// Serial operand loader, iterated accumulate engine and result streamer.
// Operands arrive W bits per beat (LSB chunk first), the accumulator is
// updated once per EXEC cycle, then streamed out W bits per beat.
module serial_op_engine #(
  parameter int N      = 64,
  parameter int W      = 4,
  parameter int ITER_W = 4
) (
  input  logic clk,
  input  logic rst,
  serial_op_engine_if.slave bus
);

  localparam int BEATS = N / W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_EXEC  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      a_q, a_d;
  logic [N-1:0]      b_q, b_d;
  logic [N-1:0]      acc_q, acc_d;
  logic [2:0]        op_q, op_d;
  logic [ITER_W-1:0] iters_q, iters_d;
  logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic [N-1:0]      f_res;
  logic [N-1:0]      mn;
  logic [N-1:0]      mx;
  logic [N-1:0]      diff;
  logic [N:0]        sum;

  // Accumulate function selected by the captured opcode.
  always_comb begin
    f_res = '0;
    mn    = (a_q < b_q) ? a_q : b_q;
    mx    = (a_q < b_q) ? b_q : a_q;
    diff  = mx - mn;
    sum   = {1'b0, a_q} + {1'b0, b_q};
    case (op_q)
      3'd0: f_res = (a_q & b_q) | acc_q;
      3'd1: f_res = (a_q ^ b_q) + acc_q;
      3'd2: f_res = diff ^ acc_q;
      3'd3: f_res = {acc_q[N-1:N/2], mn[N/2-1:0]};
      3'd4: f_res = mx + (acc_q << 1);
      3'd5: f_res = (sum[N] ? {N{1'b1}} : sum[N-1:0]) & acc_q;
      3'd6: f_res = ((a_q & b_q) + ((a_q ^ b_q) >> 1)) | acc_q;
      3'd7: f_res = {a_q[N-2:0], a_q[N-1]} ^ b_q ^ acc_q;
      default: f_res = '0;
    endcase
  end

  // Next-state and output decode; outputs come only from registered state.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    op_d         = op_q;
    iters_d      = iters_q;
    iter_cnt_d   = iter_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    bus.busy      = (state_q != S_IDLE);
    bus.state_o   = state_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d       = bus.op;
          iters_d    = bus.iters;
          a_d        = '0;
          b_d        = '0;
          if (bus.acc_clr) acc_d = '0;
          beat_cnt_d = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          a_d[beat_cnt_q*W +: W] = bus.a_in;
          b_d[beat_cnt_q*W +: W] = bus.b_in;
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            iter_cnt_d = '0;
            state_d    = S_EXEC;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      S_EXEC: begin
        acc_d = f_res;
        if (iter_cnt_q == iters_q) begin
          beat_cnt_d = '0;
          state_d    = S_DRAIN;
        end else begin
          iter_cnt_d = iter_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        bus.out_valid = 1'b1;
        bus.out_data  = acc_q[beat_cnt_q*W +: W];
        bus.out_last  = (beat_cnt_q == LAST_BEAT);
        if (bus.out_ready) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = S_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight job.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      op_q       <= '0;
      iters_q    <= '0;
      iter_cnt_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      op_q       <= op_d;
      iters_q    <= iters_d;
      iter_cnt_q <= iter_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_op_engine.sv
// Bench for serial_op_engine: a 16-bit and a 64-bit instance share the
// stimulus signals; dut_sel steers start/in_valid and the observed outputs.
module tb_serial_op_engine;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic       dut_sel;
  logic       start;
  logic [2:0] op;
  logic [3:0] iters;
  logic       acc_clr;
  logic       in_valid;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic       out_ready;

  serial_op_engine_if #(.W(4), .ITER_W(4)) if16 ();
  serial_op_engine_if #(.W(4), .ITER_W(4)) if64 ();

  assign if16.start     = start & ~dut_sel;
  assign if64.start     = start & dut_sel;
  assign if16.in_valid  = in_valid & ~dut_sel;
  assign if64.in_valid  = in_valid & dut_sel;
  assign if16.op        = op;
  assign if64.op        = op;
  assign if16.iters     = iters;
  assign if64.iters     = iters;
  assign if16.acc_clr   = acc_clr;
  assign if64.acc_clr   = acc_clr;
  assign if16.a_in      = a_in;
  assign if64.a_in      = a_in;
  assign if16.b_in      = b_in;
  assign if64.b_in      = b_in;
  assign if16.out_ready = out_ready;
  assign if64.out_ready = out_ready;

  serial_op_engine #(.N(16), .W(4), .ITER_W(4)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  serial_op_engine #(.N(64), .W(4), .ITER_W(4)) dut64 (.clk(clk), .rst(rst), .bus(if64));

  logic [1:0] state_o;
  logic       in_ready, out_valid, out_last, busy;
  logic [3:0] out_data;
  assign state_o   = dut_sel ? if64.state_o   : if16.state_o;
  assign in_ready  = dut_sel ? if64.in_ready  : if16.in_ready;
  assign out_valid = dut_sel ? if64.out_valid : if16.out_valid;
  assign out_last  = dut_sel ? if64.out_last  : if16.out_last;
  assign busy      = dut_sel ? if64.busy      : if16.busy;
  assign out_data  = dut_sel ? if64.out_data  : if16.out_data;

  // ---------------- scoreboard ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [4:0] exp_q16[$];
  logic [4:0] exp_q64[$];
  logic [4:0] e16, e64;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    chk_cnt++;
    if (act !== expv)
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    else
      pass_cnt++;
  endtask

  // Monitors: every output handshake pops one expected {last, data} beat.
  always @(negedge clk) begin
    if (if16.out_valid && if16.out_ready) begin
      if (exp_q16.size() == 0) begin
        chk_cnt++;
        $display("FAIL beat16_unexpected: got %0h, expected no beat", {if16.out_last, if16.out_data});
      end else begin
        e16 = exp_q16.pop_front();
        check("beat16", {if16.out_last, if16.out_data}, e16);
      end
    end
  end

  always @(negedge clk) begin
    if (if64.out_valid && if64.out_ready) begin
      if (exp_q64.size() == 0) begin
        chk_cnt++;
        $display("FAIL beat64_unexpected: got %0h, expected no beat", {if64.out_last, if64.out_data});
      end else begin
        e64 = exp_q64.pop_front();
        check("beat64", {if64.out_last, if64.out_data}, e64);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic sel, input logic [2:0] op_v, input logic [3:0] it_v, input logic clr);
    step();
    dut_sel = sel;
    op      = op_v;
    iters   = it_v;
    acc_clr = clr;
    start   = 1'b1;
    step();
    start   = 1'b0;
    @(negedge clk);
    check("load_entry_state", state_o, 2'd1);
    check("load_in_ready", in_ready, 1'b1);
  endtask

  task automatic do_load(input logic [63:0] a, input logic [63:0] b, input int beats, input int stall_at);
    step();
    in_valid = 1'b1;
    a_in = a[3:0];
    b_in = b[3:0];
    for (int i = 1; i < beats; i++) begin
      step();
      if (i == stall_at) begin
        in_valid = 1'b0;
        step();
        step();
        check("stall_in_hold_state", state_o, 2'd1);
      end
      in_valid = 1'b1;
      a_in = a[i*4 +: 4];
      b_in = b[i*4 +: 4];
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_job(input logic sel, input logic [2:0] op_v, input logic [3:0] it_v,
                         input logic clr, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] expv, input int stall_at, input logic stall_out,
                         input logic pulse);
    int beats;
    int cnt;
    beats = sel ? 16 : 4;
    for (int i = 0; i < beats; i++) begin
      if (sel) exp_q64.push_back({(i == beats - 1), expv[i*4 +: 4]});
      else     exp_q16.push_back({(i == beats - 1), expv[i*4 +: 4]});
    end
    do_start(sel, op_v, it_v, clr);
    do_load(a, b, beats, stall_at);
    cnt = 0;
    @(negedge clk);
    while (state_o == 2'd2 && cnt < 64) begin
      cnt++;
      if (pulse && cnt == 1) begin
        start = 1'b1;
        op    = 3'd0;
        iters = 4'hF;
      end
      @(negedge clk);
      start = 1'b0;
      op    = op_v;
      iters = it_v;
    end
    check("exec_len", cnt, int'(it_v) + 1);
    check("drain_entry_state", state_o, 2'd3);
    if (stall_out) begin
      step();
      out_ready = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check("stall_out_valid", out_valid, 1'b1);
        check("stall_out_data", out_data, expv[7:4]);
      end
      step();
      out_ready = 1'b1;
    end
    cnt = 0;
    while (busy && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("idle_after_drain", busy, 1'b0);
    check("idle_state", state_o, 2'd0);
    check("exp_queue_drained", sel ? exp_q64.size() : exp_q16.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"}, state_o, 2'd0);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_out_data"}, out_data, 4'h0);
  endtask

  // Watchdog so a stuck handshake still ends the run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b0; dut_sel = 1'b0; start = 1'b0; op = '0; iters = '0; acc_clr = 1'b0;
    in_valid = 1'b0; a_in = '0; b_in = '0; out_ready = 1'b1;
    repeat (2) step();
    @(negedge clk);
    check_reset_state("por");
    step();
    rst = 1'b1;

    // Basic AND/OR job.
    run_job(1'b0, 3'd0, 4'd0, 1'b1, 64'h00F0, 64'h0FF0, 64'h00F0, -1, 1'b0, 1'b0);

    // Reset mid-LOAD, then a chaining job must start from a cleared acc.
    do_start(1'b0, 3'd0, 4'd0, 1'b0);
    step();
    in_valid = 1'b1; a_in = 4'hF; b_in = 4'hF;
    step();
    step();
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("rst_load");
    run_job(1'b0, 3'd0, 4'd0, 1'b0, 64'h1234, 64'hFFFF, 64'h1234, -1, 1'b0, 1'b0);

    // Reset mid-DRAIN with the sink stalled so no beat is consumed.
    out_ready = 1'b0;
    do_start(1'b0, 3'd0, 4'd0, 1'b1);
    do_load(64'h5555, 64'hFFFF, 4, -1);
    @(negedge clk);
    check("drain_rst_exec", state_o, 2'd2);
    @(negedge clk);
    check("drain_rst_state", state_o, 2'd3);
    check("drain_rst_valid", out_valid, 1'b1);
    check("drain_rst_data", out_data, 4'h5);
    check("drain_rst_last", out_last, 1'b0);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_reset_state("rst_drain");

    // Iteration (acc_clr=0 also proves reset cleared acc), then chaining.
    run_job(1'b0, 3'd1, 4'd2, 1'b0, 64'h0003, 64'h0001, 64'h0006, -1, 1'b0, 1'b0);
    run_job(1'b0, 3'd5, 4'd0, 1'b0, 64'hFFF0, 64'h0020, 64'h0006, -1, 1'b0, 1'b0);
    run_job(1'b0, 3'd5, 4'd0, 1'b1, 64'hFFF0, 64'h0020, 64'h0000, -1, 1'b0, 1'b0);

    // Remaining opcodes on the narrow instance, chained.
    run_job(1'b0, 3'd6, 4'd0, 1'b1, 64'h00FF, 64'h0F0F, 64'h0807, -1, 1'b0, 1'b0);
    run_job(1'b0, 3'd3, 4'd0, 1'b0, 64'h1234, 64'h0FFF, 64'h08FF, -1, 1'b0, 1'b0);
    run_job(1'b0, 3'd4, 4'd0, 1'b0, 64'h0010, 64'h0100, 64'h12FE, -1, 1'b0, 1'b0);

    // Input and output stalls.
    run_job(1'b0, 3'd1, 4'd0, 1'b1, 64'hABCD, 64'h0000, 64'hABCD, 2, 1'b1, 1'b0);

    // Wide instance: |a-b| ^ acc, rotate op, start pulsed during EXEC.
    run_job(1'b1, 3'd2, 4'd0, 1'b1, 64'd5, 64'd9, 64'd4, -1, 1'b0, 1'b0);
    run_job(1'b1, 3'd2, 4'd1, 1'b1, 64'd5, 64'd9, 64'd0, -1, 1'b0, 1'b0);
    run_job(1'b1, 3'd7, 4'd0, 1'b1, 64'h8000000000000001, 64'h0, 64'h3, -1, 1'b0, 1'b1);

    repeat (4) @(negedge clk);
    check("final_q16_empty", exp_q16.size(), 0);
    check("final_q64_empty", exp_q64.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
